// File: rtl/rvc_mem_arb.sv
// rvc_mem_arb: shares the single D_MEM port between the core load/store path
// and an external master (program loader / debug port).
// Core has fixed priority. Ext gains priority once it has been starved long enough.
// Ext can lock the port for a bounded burst.
// Each requester gets registered read data one cycle after its read grant.
module rvc_mem_arb #(
  parameter int unsigned StarveLimit = 4,
  parameter int unsigned ExtBurstMax = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // core load/store path
  input  logic        core_req_i,
  input  logic        core_wr_en_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wr_data_i,
  input  logic [3:0]  core_byte_en_i,
  output logic        core_gnt_o,
  output logic        core_stall_o,
  output logic        core_rd_valid_o,
  output logic [31:0] core_rd_data_o,
  // external master
  input  logic        ext_req_i,
  input  logic        ext_wr_en_i,
  input  logic [31:0] ext_addr_i,
  input  logic [31:0] ext_wr_data_i,
  input  logic [3:0]  ext_byte_en_i,
  input  logic        ext_lock_i,
  output logic        ext_gnt_o,
  output logic        ext_rd_valid_o,
  output logic [31:0] ext_rd_data_o,
  output logic        ext_owner_o,
  // memory port (async read)
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wr_data_o,
  output logic [3:0]  mem_byte_en_o,
  output logic        mem_wr_en_o,
  output logic        mem_rd_en_o,
  input  logic [31:0] mem_rd_data_i
);

  localparam int unsigned StarveW = $clog2(StarveLimit + 1);
  localparam int unsigned BurstW  = $clog2(ExtBurstMax + 1);

  localparam logic [StarveW-1:0] StarveSat = StarveW'(StarveLimit);
  localparam logic [BurstW-1:0]  BurstLast = BurstW'(ExtBurstMax);
  // A one-grant burst completes on the grant that would open it, so never lock.
  localparam bit LockAllowed = (ExtBurstMax > 1);

  typedef enum logic [0:0] {StArb, StLock} state_e;

  state_e             state_q;
  logic [StarveW-1:0] starve_cnt_q;
  logic [BurstW-1:0]  burst_cnt_q;

  logic        core_rd_valid_q, ext_rd_valid_q;
  logic [31:0] core_rd_data_q, ext_rd_data_q;

  logic core_req, ext_req;
  logic core_gnt, ext_gnt;
  logic starve_sat;

  // Requests are ignored while reset is held.
  assign core_req   = core_req_i & ~rst_i;
  assign ext_req    = ext_req_i & ~rst_i;
  assign starve_sat = (starve_cnt_q == StarveSat);

  // Grant decision: Lock hands the port to Ext; otherwise Core wins unless Ext is starved.
  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (state_q == StLock) begin
      ext_gnt = ext_req;
    end else if (starve_sat) begin
      ext_gnt  = ext_req;
      core_gnt = core_req & ~ext_req;
    end else begin
      core_gnt = core_req;
      ext_gnt  = ext_req & ~core_req;
    end
  end

  assign core_gnt_o   = core_gnt;
  assign ext_gnt_o    = ext_gnt;
  assign core_stall_o = core_req & ~core_gnt;
  assign ext_owner_o  = (state_q == StLock);

  // Memory mux: the granted requester drives the port, idle port is all zeros.
  always_comb begin
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    mem_byte_en_o = '0;
    mem_wr_en_o   = 1'b0;
    mem_rd_en_o   = 1'b0;
    if (core_gnt) begin
      mem_addr_o    = core_addr_i;
      mem_wr_data_o = core_wr_data_i;
      mem_byte_en_o = core_byte_en_i;
      mem_wr_en_o   = core_wr_en_i;
      mem_rd_en_o   = ~core_wr_en_i;
    end else if (ext_gnt) begin
      mem_addr_o    = ext_addr_i;
      mem_wr_data_o = ext_wr_data_i;
      mem_byte_en_o = ext_byte_en_i;
      mem_wr_en_o   = ext_wr_en_i;
      mem_rd_en_o   = ~ext_wr_en_i;
    end
  end

  // Arbitration FSM with starvation and burst-length counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StArb;
      starve_cnt_q <= '0;
      burst_cnt_q  <= '0;
    end else begin
      // Starvation only accrues while arbitrating; any Ext grant resets it.
      if (ext_gnt) begin
        starve_cnt_q <= '0;
      end else if ((state_q == StArb) && ext_req && !starve_sat) begin
        starve_cnt_q <= starve_cnt_q + StarveW'(1);
      end

      unique case (state_q)
        StArb: begin
          if (LockAllowed && ext_gnt && ext_lock_i) begin
            state_q     <= StLock;
            burst_cnt_q <= BurstW'(1);
          end
        end
        StLock: begin
          // Release on unlock, or when this grant completes the maximum burst.
          if (!ext_lock_i || (ext_gnt && (burst_cnt_q + BurstW'(1) == BurstLast))) begin
            state_q     <= StArb;
            burst_cnt_q <= '0;
          end else if (ext_gnt) begin
            burst_cnt_q <= burst_cnt_q + BurstW'(1);
          end
        end
        default: begin
          state_q     <= StArb;
          burst_cnt_q <= '0;
        end
      endcase
    end
  end

  // Read return: capture async read data at the end of each granted read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_rd_valid_q <= 1'b0;
      ext_rd_valid_q  <= 1'b0;
      core_rd_data_q  <= '0;
      ext_rd_data_q   <= '0;
    end else begin
      core_rd_valid_q <= core_gnt & ~core_wr_en_i;
      ext_rd_valid_q  <= ext_gnt & ~ext_wr_en_i;
      if (core_gnt && !core_wr_en_i) begin
        core_rd_data_q <= mem_rd_data_i;
      end
      if (ext_gnt && !ext_wr_en_i) begin
        ext_rd_data_q <= mem_rd_data_i;
      end
    end
  end

  assign core_rd_valid_o = core_rd_valid_q;
  assign core_rd_data_o  = core_rd_data_q;
  assign ext_rd_valid_o  = ext_rd_valid_q;
  assign ext_rd_data_o   = ext_rd_data_q;

  // Structural invariants of the arbiter.
  a_one_grant: assert property (@(posedge clk_i) disable iff (rst_i)
    !(core_gnt && ext_gnt));
  a_lock_blocks_core: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == StLock) |-> !core_gnt);

endmodule
